// File: rtl/dispatch_ctrl_n.sv
// Tomasulo front-end dispatch controller: tag freelist allocation, station
// steering, CDB tag recycling and a branch-serialising resolve FSM.
module dispatch_ctrl_n #(
  parameter int unsigned NUM_RS   = 4,
  parameter int unsigned TAG_W    = 6,
  parameter int unsigned NUM_TAGS = 64,
  parameter int unsigned CLASS_W  = $clog2(NUM_RS)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_instr_valid,
  input  logic [CLASS_W-1:0] i_rs_class,
  input  logic               i_rd_write,
  input  logic               i_is_branch,
  input  logic [NUM_RS-1:0]  i_rs_full,
  output logic               o_fetch_rd_en,
  output logic [NUM_RS-1:0]  o_rs_wen,
  output logic [TAG_W-1:0]   o_rd_tag,
  output logic               o_tag_valid,
  input  logic               i_cdb_valid,
  input  logic [TAG_W-1:0]   i_cdb_tag,
  input  logic               i_cdb_rd_write,
  input  logic               i_cdb_branch,
  input  logic               i_cdb_branch_taken,
  output logic               o_br_stall,
  output logic               o_flush,
  output logic               o_fetch_next,
  output logic [TAG_W:0]     o_tags_free,
  output logic               o_err
);

  localparam int unsigned PTR_W = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;

  typedef enum logic [1:0] {IDLE, BR_PEND, FLUSH} state_t;

  state_t             state, state_nxt;
  logic [TAG_W-1:0]   fl [NUM_TAGS];
  logic [PTR_W-1:0]   head, tail;
  logic [TAG_W:0]     count;
  logic               err_q, fetch_next_q, fetch_next_set;
  logic               class_ok, fire, pop, push_req, push_ok, pool_full;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_TAGS - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    class_ok  = ({1'b0, i_rs_class} < (CLASS_W + 1)'(NUM_RS));
    pool_full = (count == (TAG_W + 1)'(NUM_TAGS));
    fire      = i_instr_valid && (state == IDLE) && class_ok &&
                !i_rs_full[i_rs_class] && (!i_rd_write || (count != '0));
    pop       = fire && i_rd_write;
    push_req  = i_cdb_valid && i_cdb_rd_write;
    // A release into a full pool is dropped; it never turns into a real push.
    push_ok   = push_req && !pool_full;
  end

  assign o_fetch_rd_en = fire;
  assign o_rs_wen      = fire ? (NUM_RS'(1) << i_rs_class) : '0;
  assign o_rd_tag      = fl[head];
  assign o_tag_valid   = (count != '0);
  assign o_tags_free   = count;
  assign o_err         = err_q;
  assign o_br_stall    = (state == BR_PEND);
  assign o_flush       = (state == FLUSH);
  assign o_fetch_next  = fetch_next_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < NUM_TAGS; i++) fl[i] <= TAG_W'(i);
      head  <= '0;
      tail  <= '0;
      count <= (TAG_W + 1)'(NUM_TAGS);
      err_q <= 1'b0;
    end else begin
      if (pop) head <= ptr_inc(head);
      if (push_ok) begin
        fl[tail] <= i_cdb_tag;
        tail     <= ptr_inc(tail);
      end
      if (push_req && pool_full) err_q <= 1'b1;
      if (pop && !push_ok)      count <= count - 1'b1;
      else if (push_ok && !pop) count <= count + 1'b1;
    end
  end

  always_comb begin
    state_nxt      = state;
    fetch_next_set = 1'b0;
    unique case (state)
      IDLE:    if (fire && i_is_branch) state_nxt = BR_PEND;
      BR_PEND: if (i_cdb_branch) begin
                 if (i_cdb_branch_taken) state_nxt = FLUSH;
                 else begin
                   state_nxt      = IDLE;
                   fetch_next_set = 1'b1;
                 end
               end
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      fetch_next_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      fetch_next_q <= fetch_next_set;
    end
  end

endmodule
